// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS register file: write-size encoding,
// architectural register indices and the jal link offset.
package mips_pkg;

    // Writeback lane size; encoding 2'b11 is not named and is merged as a word.
    typedef enum logic [1:0] {
        WSZ_BYTE = 2'b00,
        WSZ_HALF = 2'b01,
        WSZ_WORD = 2'b10
    } wsize_t;

    localparam int REG_ZERO    = 0;
    localparam int REG_RA      = 31;
    localparam int LINK_OFFSET = 4;

endpackage

// File: rtl/mips_regfile_merge.sv
// Combinational byte/half/word lane merge. Produces the value a register
// holds after a writeback of size size_i lands on top of old_i. Used by both
// the storage write path and the write-to-read forwarding path so the two
// can never disagree.
module mips_regfile_merge
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] old_i,
    input  logic [DATA_W-1:0] new_i,
    input  logic [1:0]        size_i,
    output logic [DATA_W-1:0] merged_o
);

    logic [DATA_W-1:0] lane_mask;

    // Select which low lanes come from the new data; upper lanes keep old bits.
    always_comb begin
        lane_mask = '1;
        case (size_i)
            WSZ_BYTE: lane_mask = DATA_W'(8'hFF);
            WSZ_HALF: lane_mask = DATA_W'(16'hFFFF);
            default:  lane_mask = '1;
        endcase
        merged_o = (old_i & ~lane_mask) | (new_i & lane_mask);
    end

endmodule

// File: rtl/mips_regfile.sv
// MIPS general-purpose register file: NUM_RD combinational read ports, one
// lane-merging writeback port, a jal link port and a per-register
// load-pending scoreboard. Register 0 reads as zero and ignores writes.
// Optional build macro: REGFILE_BYPASS_EN forwards the value being written
// this cycle (writeback or winning link) to matching read ports.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int LINK_REG = REG_RA
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_RD*$clog2(NUM_REGS)-1:0]    rd_addr,
    output logic [NUM_RD*DATA_W-1:0]              rd_data,
    output logic [NUM_RD-1:0]                     rd_pend,
    input  logic                                  wr_en,
    input  logic [$clog2(NUM_REGS)-1:0]           wr_addr,
    input  logic [1:0]                            wr_size,
    input  logic [DATA_W-1:0]                     wr_data,
    input  logic                                  link_en,
    input  logic [DATA_W-1:0]                     link_pc,
    input  logic                                  pend_set,
    input  logic [$clog2(NUM_REGS)-1:0]           pend_addr,
    output logic                                  pend_any
);

    localparam int AW = $clog2(NUM_REGS);
    localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);
    localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    logic              wr_do;
    logic              link_win;
    logic              pend_do;
    logic [DATA_W-1:0] wr_merged;
    logic [DATA_W-1:0] link_val;

    // Writes to r0 are dropped; a writeback to the link register beats jal.
    assign wr_do    = wr_en && (wr_addr != ZERO_A);
    assign link_win = link_en && !(wr_en && (wr_addr == LINK_A));
    assign pend_do  = pend_set && (pend_addr != ZERO_A);
    assign link_val = link_pc + DATA_W'(LINK_OFFSET);

    mips_regfile_merge #(
        .DATA_W (DATA_W)
    ) u_merge (
        .old_i    (regs_q[wr_addr]),
        .new_i    (wr_data),
        .size_i   (wr_size),
        .merged_o (wr_merged)
    );

    // Next-state for storage and scoreboard; pending set is applied last so it wins over the clear.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (link_win) begin
            regs_d[LINK_A] = link_val;
            pend_d[LINK_A] = 1'b0;
        end
        if (wr_do) begin
            regs_d[wr_addr] = wr_merged;
            pend_d[wr_addr] = 1'b0;
        end
        if (pend_do) begin
            pend_d[pend_addr] = 1'b1;
        end
    end

    // Storage and scoreboard registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    assign pend_any = |pend_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]     ra;
        logic [DATA_W-1:0] rdat;
        logic              rpend;

        assign ra = rd_addr[i*AW +: AW];
        assign rd_data[i*DATA_W +: DATA_W] = rdat;
        assign rd_pend[i] = rpend;

        // Read mux; r0 forced to zero, optional forwarding of this cycle's write.
        always_comb begin
            rdat  = '0;
            rpend = 1'b0;
            if (ra != ZERO_A) begin
                rdat  = regs_q[ra];
                rpend = pend_q[ra];
`ifdef REGFILE_BYPASS_EN
                if (!reset) begin
                    if (wr_do && (wr_addr == ra)) begin
                        rdat  = wr_merged;
                        rpend = pend_do && (pend_addr == ra);
                    end else if (link_win && (ra == LINK_A)) begin
                        rdat  = link_val;
                        rpend = pend_do && (pend_addr == ra);
                    end
                end
`endif
            end
        end
    end

endmodule
